// File: rtl/vector_ops_pkg.sv
// vector_ops_pkg: lane mode encodings and width-parameterised saturation helpers
package vector_ops_pkg;
    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam int MAXW = 64;

    // Largest value representable in a w-bit signed field; the minimum is its complement.
    function automatic logic signed [MAXW-1:0] max_of(input int w);
        return (MAXW'(1) <<< (w - 1)) - MAXW'(1);
    endfunction

    function automatic logic out_of_range(input logic signed [MAXW-1:0] r, input int w);
        return r > max_of(w) || r < ~max_of(w);
    endfunction

    // Callers truncate the result to w bits, which gives two's-complement wrap when sat=0.
    function automatic logic signed [MAXW-1:0] sat_clamp(input logic signed [MAXW-1:0] r, input int w, input logic sat);
        return !sat || !out_of_range(r, w) ? r : r[MAXW-1] ? ~max_of(w) : max_of(w);
    endfunction
endpackage

// File: rtl/vector_lane_addsub_sat.sv
// vector_lane_addsub_sat: one lane of stage-1 operand capture and stage-2 add/sub/accumulate with clamp
// Ports: clk, reset (async active-low), enable, v1/mode/clear (stage-1 control from top),
//        a/b (lane operands), s (registered result), ovf (registered out-of-range flag)
module vector_lane_addsub_sat
    import vector_ops_pkg::*;
#(
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = 11,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 v1,
    input  logic [1:0]           mode,
    input  logic                 clear,
    input  logic [IN_WIDTH-1:0]  a,
    input  logic [IN_WIDTH-1:0]  b,
    output logic [OUT_WIDTH-1:0] s,
    output logic                 ovf
);
    logic signed [IN_WIDTH-1:0]  a_q, b_q;
    logic signed [OUT_WIDTH-1:0] acc, s_n;
    logic signed [OUT_WIDTH:0]   ax, bx, accx, r;
    logic                        ovf_n;

    // One guard bit beyond OUT_WIDTH holds any single add/sub exactly before clamping.
    assign ax   = (OUT_WIDTH+1)'(a_q);
    assign bx   = (OUT_WIDTH+1)'(b_q);
    assign accx = (OUT_WIDTH+1)'(acc);

    always_comb begin
        r     = mode == MODE_ACC ? (clear ? '0 : accx) + ax : mode == MODE_SUB ? ax - bx : ax + bx;
        s_n   = OUT_WIDTH'(sat_clamp(MAXW'(r), OUT_WIDTH, SATURATE != 0));
        ovf_n = out_of_range(MAXW'(r), OUT_WIDTH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
            s   <= '0;
            ovf <= 1'b0;
        end else if (enable) begin
            a_q <= a;
            b_q <= b;
            s   <= s_n;
            ovf <= ovf_n;
            if (v1 && mode == MODE_ACC)
                acc <= s_n;
        end
    end
endmodule

// File: rtl/vector_addsub_acc_pipe.sv
// vector_addsub_acc_pipe: two-stage LANES-wide add/sub/accumulate unit with saturation and overflow flags
// Ports: clk, reset (async active-low), enable (global advance), inReady/mode/clear/A/B (input beat),
//        outReady/S/ovf (result beat), earlyOutReady (one enabled cycle ahead of outReady)
module vector_addsub_acc_pipe
    import vector_ops_pkg::*;
#(
    parameter int IN_WIDTH = 10,
    parameter int LANES    = 4,
    parameter int GUARD    = 1,
    parameter int SATURATE = 1,
    localparam int OUT_WIDTH = IN_WIDTH + GUARD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       inReady,
    input  logic [1:0]                 mode,
    input  logic                       clear,
    input  logic [LANES*IN_WIDTH-1:0]  A,
    input  logic [LANES*IN_WIDTH-1:0]  B,
    output logic                       outReady,
    output logic [LANES*OUT_WIDTH-1:0] S,
    output logic [LANES-1:0]           ovf,
    output logic                       earlyOutReady
);
    logic       v1, v2, clear_q;
    logic [1:0] mode_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            mode_q  <= '0;
            clear_q <= 1'b0;
        end else if (enable) begin
            v1      <= inReady;
            v2      <= v1;
            mode_q  <= mode;
            clear_q <= clear & inReady;
        end
    end

    assign earlyOutReady = v1;
    assign outReady      = v2;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        vector_lane_addsub_sat #(
            .IN_WIDTH (IN_WIDTH),
            .OUT_WIDTH(OUT_WIDTH),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .enable(enable),
            .v1    (v1),
            .mode  (mode_q),
            .clear (clear_q),
            .a     (A[k*IN_WIDTH +: IN_WIDTH]),
            .b     (B[k*IN_WIDTH +: IN_WIDTH]),
            .s     (S[k*OUT_WIDTH +: OUT_WIDTH]),
            .ovf   (ovf[k])
        );
    end
endmodule

// File: tb/tb_vector_addsub_acc_pipe.sv
// tb_vector_addsub_acc_pipe: scoreboard bench for the default 4-lane, 10-bit, saturating configuration
module tb_vector_addsub_acc_pipe;
    import vector_ops_pkg::*;

    logic        clk = 0, reset = 0, enable = 0, inReady = 0, clear = 0, en_q = 0;
    logic [1:0]  mode = '0;
    logic [39:0] A = '0, B = '0;
    logic        outReady, earlyOutReady;
    logic [43:0] S;
    logic [3:0]  ovf;
    int          checks = 0, passes = 0;

    typedef struct {logic [43:0] s; logic [3:0] o;} exp_t;
    exp_t sb[$];

    vector_addsub_acc_pipe dut (
        .clk(clk), .reset(reset), .enable(enable), .inReady(inReady), .mode(mode), .clear(clear),
        .A(A), .B(B), .outReady(outReady), .S(S), .ovf(ovf), .earlyOutReady(earlyOutReady)
    );

    always #5 clk = ~clk;
    always @(posedge clk) en_q <= enable;

    function automatic logic [39:0] pk_in(input int x0, x1, x2, x3);
        return {10'(x3), 10'(x2), 10'(x1), 10'(x0)};
    endfunction

    function automatic logic [43:0] pk_out(input int x0, x1, x2, x3);
        return {11'(x3), 11'(x2), 11'(x1), 11'(x0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic beat(input logic [1:0] m, input logic c, input logic [39:0] a, input logic [39:0] b,
                        input logic [43:0] es, input logic [3:0] eo);
        exp_t e;
        @(negedge clk);
        enable = 1; inReady = 1; mode = m; clear = c; A = a; B = b;
        e.s = es; e.o = eo;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        inReady = 0; clear = 0;
    endtask

    // Monitor: one result per enabled edge that leaves outReady high.
    always @(negedge clk) begin
        exp_t e;
        if (reset && en_q && outReady) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected outReady: got S=%0h ovf=%0h expected no output", S, ovf);
            end else begin
                e = sb.pop_front();
                check("S", 64'(S), 64'(e.s));
                check("ovf", 64'(ovf), 64'(e.o));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        enable = 1; inReady = 1; mode = MODE_ACC; clear = 1;
        A = pk_in(5, 6, 7, 8); B = pk_in(1, 1, 1, 1);
        repeat (3) @(negedge clk);
        check("rst outReady", 64'(outReady), 0);
        check("rst earlyOutReady", 64'(earlyOutReady), 0);
        check("rst S", 64'(S), 0);
        check("rst ovf", 64'(ovf), 0);
        inReady = 0; clear = 0; reset = 1;

        beat(MODE_ADD, 0, pk_in(1, 2, 3, 4), pk_in(10, 20, 30, 40), pk_out(11, 22, 33, 44), 4'b0000);
        idle();
        check("lat early c+1", 64'(earlyOutReady), 1);
        check("lat out c+1", 64'(outReady), 0);
        @(negedge clk);
        check("lat early c+2", 64'(earlyOutReady), 0);
        check("lat out c+2", 64'(outReady), 1);
        @(negedge clk);
        check("lat out c+3", 64'(outReady), 0);

        beat(MODE_ADD, 0, pk_in(511, -512, 511, -512), pk_in(511, -512, -511, 0), pk_out(1022, -1024, 0, -512), 4'b0000);
        beat(MODE_SUB, 0, pk_in(-512, 511, 0, 5), pk_in(511, -512, 0, -7), pk_out(-1023, 1023, 0, 12), 4'b0000);
        beat(2'b11, 0, pk_in(3, -3, 100, 0), pk_in(4, 4, -200, 0), pk_out(7, 1, -100, 0), 4'b0000);
        beat(MODE_ACC, 1, pk_in(100, 511, -512, 1), pk_in(9, 9, 9, 9), pk_out(100, 511, -512, 1), 4'b0000);
        beat(MODE_ACC, 0, pk_in(100, 511, -512, 2), '0, pk_out(200, 1022, -1024, 3), 4'b0000);
        beat(MODE_ACC, 0, pk_in(-50, 511, -512, -3), '0, pk_out(150, 1023, -1024, 0), 4'b0110);
        beat(MODE_ADD, 0, pk_in(1, 1, 1, 1), pk_in(1, 1, 1, 1), pk_out(2, 2, 2, 2), 4'b0000);
        beat(MODE_ACC, 0, pk_in(5, -1, 1, 0), '0, pk_out(155, 1022, -1023, 0), 4'b0000);
        idle();
        repeat (2) @(negedge clk);

        beat(MODE_ACC, 0, pk_in(10, 0, 0, 0), '0, pk_out(165, 1022, -1023, 0), 4'b0000);
        beat(MODE_ACC, 0, pk_in(1, 1, 1, 1), '0, pk_out(166, 1023, -1022, 1), 4'b0000);
        @(negedge clk);
        enable = 0; inReady = 1; clear = 1; A = pk_in(99, 99, 99, 99);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall outReady", 64'(outReady), 1);
            check("stall earlyOutReady", 64'(earlyOutReady), 1);
            check("stall S", 64'(S), 64'(pk_out(165, 1022, -1023, 0)));
            inReady = ~inReady; clear = ~clear;
        end
        enable = 1; inReady = 0; clear = 0;
        repeat (3) @(negedge clk);

        beat(MODE_ADD, 0, pk_in(1, 1, 1, 1), pk_in(2, 2, 2, 2), pk_out(3, 3, 3, 3), 4'b0000);
        beat(MODE_ADD, 0, pk_in(4, 4, 4, 4), pk_in(4, 4, 4, 4), pk_out(8, 8, 8, 8), 4'b0000);
        @(negedge clk);
        inReady = 0;
        #1 reset = 0;
        #1;
        check("midrst outReady", 64'(outReady), 0);
        check("midrst earlyOutReady", 64'(earlyOutReady), 0);
        check("midrst S", 64'(S), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1;
        beat(MODE_ACC, 0, pk_in(7, -7, 0, 511), '0, pk_out(7, -7, 0, 511), 4'b0000);
        idle();
        repeat (3) @(negedge clk);
        check("scoreboard drained", 64'(sb.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
